// File: rtl/iir_coef_ctrl.sv
// rtl/iir_coef_ctrl.sv - double-buffered IIR biquad coefficient bank with sample-aligned swap
// Optional shadow-bank readback port enabled by macro IIR_COEF_CTRL_READBACK_EN.
module iir_coef_ctrl #(
  parameter int SECTIONS = 4,
  parameter int COEF_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [7:0]                     wr_addr,
  input  logic [COEF_W-1:0]              wr_data,
  input  logic                           commit,
  input  logic                           sample_strobe,
  input  logic                           err_clr,
  output logic [3*SECTIONS*COEF_W-1:0]   coefs_a,
  output logic [3*SECTIONS*COEF_W-1:0]   coefs_b,
  output logic                           busy,
  output logic                           swap_done,
  output logic [15:0]                    swap_cnt,
  output logic                           err
`ifdef IIR_COEF_CTRL_READBACK_EN
  ,
  input  logic [7:0]                     rd_addr,
  output logic [COEF_W-1:0]              rd_data
`endif
);

  localparam int NCOEF  = 6 * SECTIONS;
  localparam int BANK_W = 3 * SECTIONS * COEF_W;
  localparam int AW     = $clog2(NCOEF);
  localparam logic [8:0] NCOEF_LIM = 9'(NCOEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Shadow bank holds A words in the low half and B words in the high half,
  // so a swap is a plain split of the vector.
  logic [2*BANK_W-1:0] shadow_q;
  logic [BANK_W-1:0]   live_a_q;
  logic [BANK_W-1:0]   live_b_q;
  logic                swap_done_q;
  logic [15:0]         swap_cnt_q;
  logic                err_q;

  logic          wr_fire;
  logic          wr_in_range;
  logic [AW-1:0] wr_idx;
  logic          swap;

  assign wr_ready    = (state_q != PEND);
  assign busy        = (state_q == PEND);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = ({1'b0, wr_addr} < NCOEF_LIM);
  assign wr_idx      = wr_addr[AW-1:0];
  // A strobe in the commit cycle sees IDLE/LOAD and is therefore ignored.
  assign swap        = (state_q == PEND) && sample_strobe;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: commit wins over loading, PEND waits for a strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (commit)                      state_d = PEND;
        else if (wr_fire && wr_in_range) state_d = LOAD;
      end
      LOAD: begin
        if (commit) state_d = PEND;
      end
      PEND: begin
        if (sample_strobe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow bank write; out-of-range addresses never touch storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (wr_fire && wr_in_range) begin
      shadow_q[wr_idx*COEF_W +: COEF_W] <= wr_data;
    end
  end

  // Live banks change only on the sample-aligned swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_a_q <= '0;
      live_b_q <= '0;
    end else if (swap) begin
      live_a_q <= shadow_q[BANK_W-1:0];
      live_b_q <= shadow_q[2*BANK_W-1:BANK_W];
    end
  end

  // Swap pulse and free-running wrap-around swap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_done_q <= 1'b0;
      swap_cnt_q  <= '0;
    end else begin
      swap_done_q <= swap;
      if (swap) swap_cnt_q <= swap_cnt_q + 16'd1;
    end
  end

  // Sticky error: a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        err_q <= 1'b0;
    else if (wr_fire && !wr_in_range)  err_q <= 1'b1;
    else if (err_clr)                  err_q <= 1'b0;
  end

  assign coefs_a   = live_a_q;
  assign coefs_b   = live_b_q;
  assign swap_done = swap_done_q;
  assign swap_cnt  = swap_cnt_q;
  assign err       = err_q;

`ifdef IIR_COEF_CTRL_READBACK_EN
  logic [COEF_W-1:0] rd_data_q;
  logic [AW-1:0]     rd_idx;
  assign rd_idx = rd_addr[AW-1:0];

  // Registered shadow readback, zero for addresses past the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            rd_data_q <= '0;
    else if ({1'b0, rd_addr} < NCOEF_LIM)  rd_data_q <= shadow_q[rd_idx*COEF_W +: COEF_W];
    else                                   rd_data_q <= '0;
  end

  assign rd_data = rd_data_q;
`endif

endmodule
